// File: rtl/abseq_tx_if.sv
// abseq_tx_if: control inputs and a/b protocol outputs of the abseq transmitter
interface abseq_tx_if #(
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [HOLD_W-1:0] hold_len;
  logic              inject_err;
  logic              abort;
  logic              a;
  logic              b;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  frame_cnt;
  modport master (output start, hold_len, inject_err, abort, input a, b, busy, done, frame_cnt);
  modport slave  (input start, hold_len, inject_err, abort, output a, b, busy, done, frame_cnt);
endinterface

// File: rtl/abseq_tx.sv
// abseq_tx: drives one a-phase / b-phase / a&b-hold frame per start, with error injection and frame count
module abseq_tx #(
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 8
) (
  input logic       clk,
  input logic       reset,
  abseq_tx_if.slave io
);
  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, HOLD, GAP} state_t;
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]  fc_q, fc_d;
  logic              inj_q, inj_d, a_q, a_d, b_q, b_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = IDLE;
    cnt_d   = cnt_q;
    inj_d   = inj_q;
    fc_d    = fc_q;
    case (state_q)
      IDLE: if (io.start) begin
        state_d = SEND_A;
        cnt_d   = (io.hold_len == '0) ? HOLD_W'(1) : io.hold_len;
        inj_d   = io.inject_err;
      end
      SEND_A: state_d = SEND_B;
      SEND_B: state_d = HOLD;
      HOLD: begin
        state_d = (cnt_q == HOLD_W'(1)) ? GAP : HOLD;
        cnt_d   = cnt_q - HOLD_W'(1);
      end
      GAP: fc_d = io.abort ? fc_q : fc_q + CNT_W'(1);
      default: state_d = IDLE;
    endcase
    if (io.abort && state_q != IDLE) state_d = IDLE;
    // outputs are decoded from the next state so they appear registered in the state's own cycle
    a_d    = state_d == SEND_A || state_d == HOLD;
    b_d    = (state_d == SEND_B && !inj_d) || state_d == HOLD;
    busy_d = state_d != IDLE;
    done_d = state_q == GAP && !io.abort;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      inj_q   <= 1'b0;
      fc_q    <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inj_q   <= inj_d;
      fc_q    <= fc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign io.a         = a_q;
  assign io.b         = b_q;
  assign io.busy      = busy_q;
  assign io.done      = done_q;
  assign io.frame_cnt = fc_q;
endmodule

// File: tb/tb_abseq_tx.sv
// tb_abseq_tx: directed vector table plus randomized run against a frame-plan reference model
module tb_abseq_tx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  abseq_tx_if #(.HOLD_W(4), .CNT_W(8)) io();
  abseq_tx #(.HOLD_W(4), .CNT_W(8)) dut (.clk(clk), .reset(reset), .io(io));
  typedef struct {
    logic       r, s;
    logic [3:0] h;
    logic       i, ab;
    logic [3:0] o;
    logic [7:0] c;
  } vec_t;
  vec_t       tv[$];
  logic [2:0] plan[$];
  logic       m_done = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  int         errs = 0;
  int         checks = 0;
  task automatic add(input logic r, s, input logic [3:0] h, input logic i, ab, input logic [3:0] o, input logic [7:0] c);
    vec_t v;
    v.r = r; v.s = s; v.h = h; v.i = i; v.ab = ab; v.o = o; v.c = c;
    tv.push_back(v);
  endtask
  task automatic chk(input string n, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got {a,b,busy,done,cnt}=%h want %h", n, got, want);
    end
  endtask
  task automatic model_step();
    int h;
    if (reset) begin
      plan.delete();
      m_done = 1'b0;
      m_cnt  = 8'd0;
    end else begin
      m_done = 1'b0;
      if (plan.size() == 0) begin
        if (io.start) begin
          h = (io.hold_len == 4'd0) ? 1 : int'(io.hold_len);
          plan.push_back(3'b101);
          plan.push_back({1'b0, ~io.inject_err, 1'b1});
          repeat (h) plan.push_back(3'b111);
          plan.push_back(3'b001);
        end
      end else if (io.abort) plan.delete();
      else begin
        if (plan.size() == 1) begin
          m_done = 1'b1;
          m_cnt  = m_cnt + 8'd1;
        end
        void'(plan.pop_front());
      end
    end
  endtask
  function automatic logic [11:0] dut_out();
    return {io.a, io.b, io.busy, io.done, io.frame_cnt};
  endfunction
  function automatic logic [11:0] model_out();
    logic [2:0] p;
    p = (plan.size() != 0) ? plan[0] : 3'b000;
    return {p, m_done, m_cnt};
  endfunction
  task automatic cyc(input logic r, s, input logic [3:0] h, input logic i, ab);
    reset = r; io.start = s; io.hold_len = h; io.inject_err = i; io.abort = ab;
    @(posedge clk);
    model_step();
    #1;
    chk("model", dut_out(), model_out());
  endtask
  initial begin
    // reset, then nominal hold=3 frame with ignored changes while busy
    add(1,0,0,0,0, 4'b0000, 0); add(1,0,0,0,0, 4'b0000, 0); add(0,0,0,0,0, 4'b0000, 0);
    add(0,1,3,0,0, 4'b1010, 0); add(0,0,0,1,0, 4'b0110, 0); add(0,0,0,0,0, 4'b1110, 0);
    add(0,1,0,0,0, 4'b1110, 0); add(0,0,0,0,0, 4'b1110, 0); add(0,0,0,0,0, 4'b0010, 0);
    add(0,0,0,0,0, 4'b0001, 1);
    // injected error, hold=2
    add(0,1,2,1,0, 4'b1010, 1); add(0,0,2,0,0, 4'b0010, 1); add(0,0,0,0,0, 4'b1110, 1);
    add(0,0,0,0,0, 4'b1110, 1); add(0,0,0,0,0, 4'b0010, 1); add(0,0,0,0,0, 4'b0001, 2);
    // abort in second hold cycle of a hold=5 frame
    add(0,1,5,0,0, 4'b1010, 2); add(0,0,5,0,0, 4'b0110, 2); add(0,0,5,0,0, 4'b1110, 2);
    add(0,0,5,0,0, 4'b1110, 2); add(0,0,5,0,1, 4'b0000, 2); add(0,0,5,0,0, 4'b0000, 2);
    // start beats abort in idle, hold=0, start held through done cycle for back-to-back
    add(0,1,0,0,1, 4'b1010, 2); add(0,1,0,0,0, 4'b0110, 2); add(0,1,0,0,0, 4'b1110, 2);
    add(0,1,0,0,0, 4'b0010, 2); add(0,1,0,0,0, 4'b0001, 3); add(0,1,0,0,0, 4'b1010, 3);
    add(0,0,0,0,0, 4'b0110, 3); add(0,0,0,0,0, 4'b1110, 3); add(0,0,0,0,0, 4'b0010, 3);
    add(0,0,0,0,0, 4'b0001, 4);
    // reset mid-frame, then reset overriding start
    add(0,1,5,0,0, 4'b1010, 4); add(0,0,5,0,0, 4'b0110, 4); add(0,0,5,0,0, 4'b1110, 4);
    add(1,0,5,0,0, 4'b0000, 0); add(0,0,5,0,0, 4'b0000, 0); add(1,1,5,0,1, 4'b0000, 0);
    add(0,0,5,0,0, 4'b0000, 0);
    for (int k = 0; k < tv.size(); k++) begin
      cyc(tv[k].r, tv[k].s, tv[k].h, tv[k].i, tv[k].ab);
      chk($sformatf("vec%0d", k), dut_out(), {tv[k].o, tv[k].c});
    end
    // 256 hold=1 frames with start held during busy: counter wraps to 0
    for (int f = 0; f < 256; f++) begin
      repeat (4) cyc(0, 1, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
    end
    chk("wrap", dut_out(), {4'b0001, 8'd0});
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, 4'($urandom),
          1'($urandom), $urandom_range(0, 29) == 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
